// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan decoder block.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_if.sv
// Control/status bundle for scan_decoder: select inputs and registered decode outputs.
interface scan_decoder_if #(
  parameter int N = 2
);
  logic             en;
  logic             mode;
  logic [N-1:0]     sel;
  logic [2**N-1:0]  out;
  logic [N-1:0]     code;
  logic             wrap;

  modport master (output en, mode, sel, input out, code, wrap);
  modport slave  (input en, mode, sel, output out, code, wrap);
endinterface

// File: rtl/scan_decoder_decoder_n.sv
// Combinational N-to-2^N one-hot decoder; code k drives bit 2^N-1-k, all zeros when disabled.
module decoder_n #(
  parameter int N = 2
) (
  input  logic              en_i,
  input  logic [N-1:0]      code_i,
  output logic [2**N-1:0]   dec_o
);

  always_comb begin
    dec_o = '0;
    for (int k = 0; k < 2**N; k++) begin
      dec_o[2**N-1-k] = en_i && (code_i == N'(k));
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with direct and auto-scan modes and a per-sweep wrap pulse.
module scan_decoder
  import decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter int DIV        = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  scan_decoder_if.slave bus
);

  localparam int             W        = 2**N;
  localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
  localparam logic [W-1:0]   OUT_IDLE = {W{ACTIVE_LOW}};

  state_t          state_q, state_d;
  logic [N-1:0]    code_q, code_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [W-1:0]    out_q, out_d, dec;
  logic            wrap_q, wrap_d;

  // Any mode change (or entry from IDLE) reloads from sel, so it beats a terminal count.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
    end else if (bus.mode == MODE_DIRECT) begin
      state_d = DIRECT;
      code_d  = bus.sel;
      pre_d   = '0;
    end else if (state_q != SCAN) begin
      state_d = SCAN;
      code_d  = bus.sel;
      pre_d   = '0;
    end else begin
      state_d = SCAN;
      if (pre_q == PRE_LAST) begin
        code_d = code_q + N'(1);
        pre_d  = '0;
        wrap_d = (code_q == {N{1'b1}});
      end else begin
        pre_d  = pre_q + PW'(1);
      end
    end
  end

  // Decoding the next code keeps out and code in the same register stage.
  decoder_n #(.N(N)) u_dec (
    .en_i   (bus.en),
    .code_i (code_d),
    .dec_o  (dec)
  );

  assign out_d = ACTIVE_LOW ? ~dec : dec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      pre_q   <= '0;
      out_q   <= OUT_IDLE;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pre_q   <= pre_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.code = code_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: directed vector table, ACTIVE_LOW sweep, and randomized run against a sweep model.
module tb_scan_decoder;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scan_decoder_if #(.N(2)) ifa ();
  scan_decoder_if #(.N(3)) ifb ();

  scan_decoder #(.N(2), .DIV(3), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset(rst_a), .bus(ifa.slave));
  scan_decoder #(.N(3), .DIV(1), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .bus(ifb.slave));

  typedef struct {
    bit         r;
    bit         e;
    bit         m;
    logic [1:0] s;
    logic [1:0] c;
    bit         w;
    logic [3:0] o;
  } vec_t;

  vec_t tbl[$];

  // Sweep model: in SCAN the code is start + elapsed/DIV, wrapping modulo 2^N.
  int m_t[2], m_start[2], m_code[2];
  bit m_act[2], m_wrap[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit e, input bit m, input int s,
                     input int c, input bit w, input logic [3:0] o);
    vec_t v;
    v.r = r; v.e = e; v.m = m; v.s = 2'(s); v.c = 2'(c); v.w = w; v.o = o;
    tbl.push_back(v);
  endtask

  task automatic model_step(input int d, input bit r, input bit e, input bit md,
                            input int s, input int n, input int div);
    int msz;
    msz = 1 << n;
    if (r) begin
      m_t[d] = -1; m_code[d] = 0; m_act[d] = 0; m_wrap[d] = 0;
    end else if (!e) begin
      m_t[d] = -1; m_act[d] = 0; m_wrap[d] = 0;
    end else if (!md) begin
      m_t[d] = -1; m_act[d] = 1; m_code[d] = s; m_wrap[d] = 0;
    end else begin
      if (m_t[d] < 0) begin
        m_t[d] = 0;
        m_start[d] = s;
      end else begin
        m_t[d]++;
      end
      m_code[d] = (m_start[d] + m_t[d] / div) % msz;
      m_wrap[d] = (m_t[d] > 0) && (m_t[d] % div == 0) && (m_code[d] == 0);
      m_act[d]  = 1;
    end
  endtask

  function automatic logic [31:0] exp_out(input int code, input bit act, input int n, input bit al);
    int          msz;
    logic [31:0] v, mask;
    msz  = 1 << n;
    mask = (32'd1 << msz) - 32'd1;
    v    = act ? (32'd1 << (msz - 1 - code)) : 32'd0;
    if (al) v = ~v & mask;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ra, ea, ma, rb, eb, mb;
    int   sa, sb;
    logic [7:0] eo;

    rst_a = 1'b1; ifa.en = 1'b1; ifa.mode = 1'b1; ifa.sel = 2'd2;
    rst_b = 1'b1; ifb.en = 1'b0; ifb.mode = 1'b0; ifb.sel = 3'd0;

    // reset held with en/mode high, then SCAN entry from sel=2 and a full sweep
    add(1,1,1,2, 0,0,4'b0000); add(1,1,1,2, 0,0,4'b0000);
    add(0,1,1,2, 2,0,4'b0010); add(0,1,1,0, 2,0,4'b0010); add(0,1,1,0, 2,0,4'b0010);
    add(0,1,1,0, 3,0,4'b0001); add(0,1,1,0, 3,0,4'b0001); add(0,1,1,0, 3,0,4'b0001);
    add(0,1,1,0, 0,1,4'b1000); add(0,1,1,0, 0,0,4'b1000); add(0,1,1,0, 0,0,4'b1000);
    add(0,1,1,0, 1,0,4'b0100); add(0,1,1,0, 1,0,4'b0100); add(0,1,1,0, 1,0,4'b0100);
    // DIRECT decoding
    add(0,1,0,0, 0,0,4'b1000); add(0,1,0,1, 1,0,4'b0100);
    add(0,1,0,2, 2,0,4'b0010); add(0,1,0,3, 3,0,4'b0001);
    // mid-scan disable, then restart from sel=1 with full dwell
    add(0,1,1,3, 3,0,4'b0001); add(0,1,1,3, 3,0,4'b0001);
    add(0,0,1,3, 3,0,4'b0000); add(0,0,1,3, 3,0,4'b0000);
    add(0,1,1,1, 1,0,4'b0100); add(0,1,1,1, 1,0,4'b0100); add(0,1,1,1, 1,0,4'b0100);
    add(0,1,1,1, 2,0,4'b0010); add(0,1,1,1, 2,0,4'b0010); add(0,1,1,1, 2,0,4'b0010);
    add(0,1,1,1, 3,0,4'b0001); add(0,1,1,1, 3,0,4'b0001); add(0,1,1,1, 3,0,4'b0001);
    // reset on terminal count at code 3: no wrap
    add(1,1,1,1, 0,0,4'b0000); add(0,0,1,1, 0,0,4'b0000);
    // entry load of 0 raises no wrap; mode change at terminal count loads sel
    add(0,1,1,0, 0,0,4'b1000); add(0,1,1,0, 0,0,4'b1000); add(0,1,1,0, 0,0,4'b1000);
    add(0,1,0,2, 2,0,4'b0010); add(0,1,1,1, 1,0,4'b0100);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_a = tbl[i].r; ifa.en = tbl[i].e; ifa.mode = tbl[i].m; ifa.sel = tbl[i].s;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out", i),  32'(ifa.out),  32'(tbl[i].o));
      chk($sformatf("vec%0d_code", i), 32'(ifa.code), 32'(tbl[i].c));
      chk($sformatf("vec%0d_wrap", i), 32'(ifa.wrap), 32'(tbl[i].w));
    end

    // ACTIVE_LOW, DIV=1, N=3 sweep from sel=0
    chk("b_reset_out", 32'(ifb.out), 32'h0000_00ff);
    rst_b = 1'b0; ifb.en = 1'b1; ifb.mode = 1'b1; ifb.sel = 3'd0;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      ifb.sel = 3'($urandom_range(0, 7));
      eo = ~(8'h80 >> (i % 8));
      chk($sformatf("b_sweep%0d_out", i),  32'(ifb.out),  32'(eo));
      chk($sformatf("b_sweep%0d_code", i), 32'(ifb.code), 32'(i % 8));
      chk($sformatf("b_sweep%0d_wrap", i), 32'(ifb.wrap), 32'((i > 0) && (i % 8 == 0)));
    end

    // randomized run against the sweep model
    ma = 1'b0; mb = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      ra = (cyc == 0) || ($urandom_range(0, 63) == 0);
      rb = (cyc == 0) || ($urandom_range(0, 63) == 0);
      ea = ($urandom_range(0, 9) != 0);
      eb = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 11) == 0) ma = ~ma;
      if ($urandom_range(0, 11) == 0) mb = ~mb;
      sa = $urandom_range(0, 3);
      sb = $urandom_range(0, 7);
      rst_a = ra; ifa.en = ea; ifa.mode = ma; ifa.sel = 2'(sa);
      rst_b = rb; ifb.en = eb; ifb.mode = mb; ifb.sel = 3'(sb);
      model_step(0, ra, ea, ma, sa, 2, 3);
      model_step(1, rb, eb, mb, sb, 3, 1);
      @(posedge clk); #1;
      chk("rand_a_out",  32'(ifa.out),  exp_out(m_code[0], m_act[0], 2, 1'b0));
      chk("rand_a_code", 32'(ifa.code), 32'(m_code[0]));
      chk("rand_a_wrap", 32'(ifa.wrap), 32'(m_wrap[0]));
      chk("rand_b_out",  32'(ifb.out),  exp_out(m_code[1], m_act[1], 3, 1'b1));
      chk("rand_b_code", 32'(ifb.code), 32'(m_code[1]));
      chk("rand_b_wrap", 32'(ifb.wrap), 32'(m_wrap[1]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
